// File: rtl/alpha_mult_pkg.sv
// alpha_mult_pkg
//   Shared definitions for the alpha multiplier arbiter.
//   - Default amplitude and tag widths.
//   - Alpha encoding constants. Alpha is a 2-bit signed value per component.
//   - Complex amplitude struct {r, i} at the default width.
//   - alpha_legal(): true when exactly one component is +/-1 and the other is 0.
package alpha_mult_pkg;

    localparam int COMPLEX_BIT_DEF = 24;
    localparam int TAG_W_DEF       = 4;

    localparam logic signed [1:0] ALPHA_POS = 2'sd1;
    localparam logic signed [1:0] ALPHA_NEG = -2'sd1;

    typedef struct packed {
        logic signed [COMPLEX_BIT_DEF-1:0] r;
        logic signed [COMPLEX_BIT_DEF-1:0] i;
    } cplx_t;

    function automatic logic alpha_legal(input logic signed [1:0] ar,
                                         input logic signed [1:0] ai);
        logic r_unit;
        logic i_unit;
        r_unit = (ar == ALPHA_POS) || (ar == ALPHA_NEG);
        i_unit = (ai == ALPHA_POS) || (ai == ALPHA_NEG);
        return (r_unit && (ai == 2'sd0)) || (i_unit && (ar == 2'sd0));
    endfunction

endpackage

// File: rtl/alpha_mult_arbiter_phase_mult.sv
// phase_mult
//   Combinational product amp * alpha with alpha in {+1, -1, +i, -i}.
//   The real component of alpha takes priority; anything that is not a unit
//   value gives a zero product. Negation wraps at W bits (no saturation).
// Ports
//   alpha_r, alpha_i : signed 2-bit alpha components
//   amp_r, amp_i     : signed W-bit amplitude
//   prod_r, prod_i   : signed W-bit product
module phase_mult
    import alpha_mult_pkg::*;
#(
    parameter int W = COMPLEX_BIT_DEF
) (
    input  logic signed [1:0]   alpha_r,
    input  logic signed [1:0]   alpha_i,
    input  logic signed [W-1:0] amp_r,
    input  logic signed [W-1:0] amp_i,
    output logic signed [W-1:0] prod_r,
    output logic signed [W-1:0] prod_i
);

    always_comb begin
        prod_r = '0;
        prod_i = '0;
        if (alpha_r == ALPHA_POS) begin
            prod_r = amp_r;
            prod_i = amp_i;
        end else if (alpha_r == ALPHA_NEG) begin
            prod_r = -amp_r;
            prod_i = -amp_i;
        end else if (alpha_i == ALPHA_POS) begin
            prod_r = -amp_i;
            prod_i = amp_r;
        end else if (alpha_i == ALPHA_NEG) begin
            prod_r = amp_i;
            prod_i = -amp_r;
        end
    end

endmodule

// File: rtl/alpha_mult_arbiter.sv
// alpha_mult_arbiter
//   Shares one phase multiplier between two requesters (0: gate update,
//   1: measurement/cofactor). Round-robin grant, one registered result stage
//   with full back-pressure, tag carried through with each request.
// Ports
//   clk, rst                   : clock, asynchronous active-high reset
//   req_valid[1:0]             : request valid per requester
//   req_ready[1:0]             : combinational grant (one-hot or zero)
//   req_alpha_r/i0, _r/i1      : signed 2-bit alpha per requester
//   req_amp_r/i0, _r/i1        : signed amplitude per requester
//   req_tag0, req_tag1         : request tags
//   out_valid / out_ready      : result handshake
//   out_amp_r/i, out_id, out_tag : result product, issuing requester, tag
//   alpha_err                  : sticky illegal-alpha flag (only when the
//                                ALPHA_ERR_EN macro is defined)
module alpha_mult_arbiter
    import alpha_mult_pkg::*;
#(
    parameter int COMPLEX_BIT = COMPLEX_BIT_DEF,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic signed [1:0]             req_alpha_r0,
    input  logic signed [1:0]             req_alpha_i0,
    input  logic signed [COMPLEX_BIT-1:0] req_amp_r0,
    input  logic signed [COMPLEX_BIT-1:0] req_amp_i0,
    input  logic [TAG_W-1:0]              req_tag0,
    input  logic signed [1:0]             req_alpha_r1,
    input  logic signed [1:0]             req_alpha_i1,
    input  logic signed [COMPLEX_BIT-1:0] req_amp_r1,
    input  logic signed [COMPLEX_BIT-1:0] req_amp_i1,
    input  logic [TAG_W-1:0]              req_tag1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [COMPLEX_BIT-1:0] out_amp_r,
    output logic signed [COMPLEX_BIT-1:0] out_amp_i,
    output logic                          out_id,
    output logic [TAG_W-1:0]              out_tag
`ifdef ALPHA_ERR_EN
    ,
    output logic                          alpha_err
`endif
);

    logic                          stage_free;
    logic                          gnt_any;
    logic                          gnt_id;
    logic                          last_grant;
    logic                          hs;
    logic signed [1:0]             sel_alpha_r;
    logic signed [1:0]             sel_alpha_i;
    logic signed [COMPLEX_BIT-1:0] sel_amp_r;
    logic signed [COMPLEX_BIT-1:0] sel_amp_i;
    logic [TAG_W-1:0]              sel_tag;
    logic signed [COMPLEX_BIT-1:0] prod_r;
    logic signed [COMPLEX_BIT-1:0] prod_i;

    assign stage_free = !out_valid || out_ready;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_any = 1'b1;
            gnt_id  = !last_grant;
        end else if (req_valid[0]) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
        end else if (req_valid[1]) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    assign hs        = stage_free && gnt_any;
    assign req_ready = hs ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    assign sel_alpha_r = gnt_id ? req_alpha_r1 : req_alpha_r0;
    assign sel_alpha_i = gnt_id ? req_alpha_i1 : req_alpha_i0;
    assign sel_amp_r   = gnt_id ? req_amp_r1   : req_amp_r0;
    assign sel_amp_i   = gnt_id ? req_amp_i1   : req_amp_i0;
    assign sel_tag     = gnt_id ? req_tag1     : req_tag0;

    phase_mult #(
        .W (COMPLEX_BIT)
    ) u_phase_mult (
        .alpha_r (sel_alpha_r),
        .alpha_i (sel_alpha_i),
        .amp_r   (sel_amp_r),
        .amp_i   (sel_amp_i),
        .prod_r  (prod_r),
        .prod_i  (prod_i)
    );

    // Data registers only move on a handshake; a drain without a new load
    // just drops out_valid and leaves the last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_amp_r  <= '0;
            out_amp_i  <= '0;
            out_id     <= 1'b0;
            out_tag    <= '0;
            last_grant <= 1'b1;
        end else if (hs) begin
            out_valid  <= 1'b1;
            out_amp_r  <= prod_r;
            out_amp_i  <= prod_i;
            out_id     <= gnt_id;
            out_tag    <= sel_tag;
            last_grant <= gnt_id;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALPHA_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alpha_err <= 1'b0;
        end else if (hs && !alpha_legal(sel_alpha_r, sel_alpha_i)) begin
            alpha_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alpha_mult_arbiter.sv
module tb_alpha_mult_arbiter;

    localparam int W  = 24;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_alpha_r0, req_alpha_i0, req_alpha_r1, req_alpha_i1;
    logic [W-1:0]  req_amp_r0, req_amp_i0, req_amp_r1, req_amp_i1;
    logic [TW-1:0] req_tag0, req_tag1;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_amp_r, out_amp_i;
    logic          out_id;
    logic [TW-1:0] out_tag;
`ifdef ALPHA_ERR_EN
    logic          alpha_err;
`endif

    int tests = 0;
    int fails = 0;

    alpha_mult_arbiter #(.COMPLEX_BIT(W), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_alpha_r0 (req_alpha_r0),
        .req_alpha_i0 (req_alpha_i0),
        .req_amp_r0   (req_amp_r0),
        .req_amp_i0   (req_amp_i0),
        .req_tag0     (req_tag0),
        .req_alpha_r1 (req_alpha_r1),
        .req_alpha_i1 (req_alpha_i1),
        .req_amp_r1   (req_amp_r1),
        .req_amp_i1   (req_amp_i1),
        .req_tag1     (req_tag1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_amp_r    (out_amp_r),
        .out_amp_i    (out_amp_i),
        .out_id       (out_id),
        .out_tag      (out_tag)
`ifdef ALPHA_ERR_EN
        ,
        .alpha_err    (alpha_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the result slot as described in words, with the
    // product computed by ordinary complex multiplication.
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_r     = '0;
    logic [W-1:0]  m_i     = '0;
    logic          m_id    = 1'b0;
    logic [TW-1:0] m_tag   = '0;
    logic          m_last  = 1'b1;
    logic          m_err   = 1'b0;
    int            m_g;

    function automatic int pick(input logic mv, input logic ml, input logic ordy,
                                input logic [1:0] v);
        if (mv && !ordy) return -1;
        if (v == 2'b11) return ml ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    function automatic void model_prod(input int ar, input int ai, input int a, input int b,
                                       output logic [W-1:0] r, output logic [W-1:0] i);
        int     wr;
        int     wi;
        longint re;
        longint im;
        wr = 0;
        wi = 0;
        if (ar == 1) wr = 1;
        else if (ar == -1) wr = -1;
        else if (ai == 1) wi = 1;
        else if (ai == -1) wi = -1;
        re = longint'(a) * wr - longint'(b) * wi;
        im = longint'(a) * wi + longint'(b) * wr;
        r = re[W-1:0];
        i = im[W-1:0];
    endfunction

    function automatic logic illegal(input int ar, input int ai);
        return !(((ar == 1 || ar == -1) && ai == 0) || (ar == 0 && (ai == 1 || ai == -1)));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0; m_r = '0; m_i = '0; m_id = 1'b0;
            m_tag = '0; m_last = 1'b1; m_err = 1'b0;
        end else begin
            m_g = pick(m_valid, m_last, out_ready, req_valid);
            if (m_g == 0) begin
                model_prod($signed(req_alpha_r0), $signed(req_alpha_i0),
                           $signed(req_amp_r0), $signed(req_amp_i0), m_r, m_i);
                if (illegal($signed(req_alpha_r0), $signed(req_alpha_i0))) m_err = 1'b1;
                m_id = 1'b0; m_tag = req_tag0; m_valid = 1'b1; m_last = 1'b0;
            end else if (m_g == 1) begin
                model_prod($signed(req_alpha_r1), $signed(req_alpha_i1),
                           $signed(req_amp_r1), $signed(req_amp_i1), m_r, m_i);
                if (illegal($signed(req_alpha_r1), $signed(req_alpha_i1))) m_err = 1'b1;
                m_id = 1'b1; m_tag = req_tag1; m_valid = 1'b1; m_last = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] e24(input int v);
        return {8'd0, v[W-1:0]};
    endfunction

    task automatic compare_model();
        int g;
        logic [1:0] er;
        g  = pick(m_valid, m_last, out_ready, req_valid);
        er = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("cyc_req_ready", 32'(req_ready), 32'(er));
        chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        chk("cyc_out_amp_r", 32'(out_amp_r), 32'(m_r));
        chk("cyc_out_amp_i", 32'(out_amp_i), 32'(m_i));
        chk("cyc_out_id",    32'(out_id),    32'(m_id));
        chk("cyc_out_tag",   32'(out_tag),   32'(m_tag));
`ifdef ALPHA_ERR_EN
        chk("cyc_alpha_err", 32'(alpha_err), 32'(m_err));
`endif
    endtask

    // One clock: model check mid-cycle, then step to just after the edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) compare_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input int ar, input int ai, input int a, input int b, input int tag);
        req_alpha_r0 = 2'(ar); req_alpha_i0 = 2'(ai);
        req_amp_r0 = W'(a); req_amp_i0 = W'(b); req_tag0 = TW'(tag);
    endtask

    task automatic set_r1(input int ar, input int ai, input int a, input int b, input int tag);
        req_alpha_r1 = 2'(ar); req_alpha_i1 = 2'(ai);
        req_amp_r1 = W'(a); req_amp_i1 = W'(b); req_tag1 = TW'(tag);
    endtask

    task automatic one_req0(input string nm, input int ar, input int ai, input int a, input int b,
                            input int exp_r, input int exp_i);
        set_r0(ar, ai, a, b, 6);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk({nm, "_r"}, 32'(out_amp_r), e24(exp_r));
        chk({nm, "_i"}, 32'(out_amp_i), e24(exp_i));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b1;
        set_r0(0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0);
        #7;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_amp_r", 32'(out_amp_r), 32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single request from requester 0
        set_r0(1, 0, 5, -3, 2);
        req_valid = 2'b01;
        #1 chk("t1_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_amp_r", 32'(out_amp_r), e24(5));
        chk("t1_out_amp_i", 32'(out_amp_i), e24(-3));
        chk("t1_out_id",    32'(out_id),    32'd0);
        chk("t1_out_tag",   32'(out_tag),   32'd2);

        // asynchronous reset while a result is pending
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_amp_r", 32'(out_amp_r), 32'd0);
        chk("arst_out_tag",   32'(out_tag),   32'd0);
        rst = 1'b0;

        // both valid: first tie after reset goes to 0, then alternate
        set_r1(1, 0, 100, 200, 5);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_id",    32'(out_id),    32'(k % 2));
            chk("rr_out_tag",   32'(out_tag),   (k % 2 == 1) ? 32'd5 : 32'd2);
        end
        req_valid = 2'b00;

        // product rules
        one_req0("pos_i",     0,  1,  7,  2,  -2,  7);
        one_req0("neg_i",     0, -1,  7,  2,   2, -7);
        one_req0("neg_r_wrap", -1, 0, -8388608, 0, -8388608, 0);
        one_req0("neg_r",    -1,  0,  3,  4,  -3, -4);
        one_req0("both_nz",   1,  1,  3,  4,   3,  4);
        one_req0("r_minus2", -2,  0,  5,  5,   0,  0);
        one_req0("zero_alpha", 0, 0,  9,  9,   0,  0);
`ifdef ALPHA_ERR_EN
        chk("err_set", 32'(alpha_err), 32'd1);
        one_req0("legal_after", 1, 0, 1, 1, 1, 1);
        chk("err_sticky", 32'(alpha_err), 32'd1);
`endif

        // back-pressure
        set_r0(1, 0, 11, 12, 3);
        req_valid = 2'b01;
        tick();
        set_r1(0, 1, 20, 30, 9);
        req_valid = 2'b10;
        out_ready = 1'b0;
        #1 chk("bp_req_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_amp_r", 32'(out_amp_r), e24(11));
            chk("bp_out_tag",   32'(out_tag),   32'd3);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        chk("bp_new_id",    32'(out_id),    32'd1);
        chk("bp_new_tag",   32'(out_tag),   32'd9);
        chk("bp_new_amp_r", 32'(out_amp_r), e24(-30));
        chk("bp_new_amp_i", 32'(out_amp_i), e24(20));
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold",  32'(out_amp_r), e24(-30));

        // last grant was 1; a tie now goes to 0
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        chk("tie_after_1", 32'(out_id), 32'd0);
        tick();

`ifdef ALPHA_ERR_EN
        rst = 1'b1;
        #1 chk("err_cleared", 32'(alpha_err), 32'd0);
        rst = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alpha_mult_arbiter.md
# alpha_mult_arbiter

Shares a single phase-multiplier datapath (amplitude × alpha, alpha ∈ {+1, −1, +i, −i}) between two requesters: requester 0 is the gate-update path, requester 1 is the measurement/cofactor path. Arbitration is round-robin with valid/ready handshakes on both request ports and on the result port. There is one registered result stage with full back-pressure. Requests carry a tag so each requester can match its returned amplitudes.

## Interface
- COMPLEX_BIT, 24, width of each real/imaginary amplitude component (two's complement)
- TAG_W, 4, width of the request tag carried through to the result
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid[1:0]  in  2  request valid, one bit per requester
- req_ready[1:0]  out  2  request accepted this cycle (combinational grant)
- req_alpha_r0 / req_alpha_i0  in  2 each  signed alpha components, requester 0
- req_amp_r0 / req_amp_i0  in  COMPLEX_BIT each  amplitude, requester 0
- req_tag0  in  TAG_W  tag, requester 0
- req_alpha_r1, req_alpha_i1, req_amp_r1, req_amp_i1, req_tag1  in  same widths as above, requester 1
- out_valid  out  1  result register holds valid data
- out_ready  in  1  consumer accepts result
- out_amp_r / out_amp_i  out  COMPLEX_BIT each  product
- out_id  out  1  index of the requester that issued this result
- out_tag  out  TAG_W  tag of that request
- alpha_err  out  1  sticky illegal-alpha flag (present only with ALPHA_ERR_EN)

## Operation
- Stage-free signal: stage_free = !out_valid || out_ready.
- Grant (combinational, when stage_free):
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - req_ready[k] = stage_free && grant==k. At most one bit of req_ready is high in any cycle.
- On a handshake (req_valid[k] && req_ready[k]):
  - The result register loads the product, k, and the tag.
  - out_valid is set.
  - last_grant is set to k.
- If out_valid && out_ready and there is no new handshake, out_valid clears. The data registers hold their value.
- Product rules, evaluated in priority order:
  - alpha_r==+1: (a, b)
  - alpha_r==−1: (−a, −b)
  - alpha_i==+1: (−b, a)
  - alpha_i==−1: (b, −a)
  - Any other value: (0, 0)
- Negation wraps at COMPLEX_BIT width: −(−2^(COMPLEX_BIT−1)) = −2^(COMPLEX_BIT−1). There is no saturation.
- Legal alpha: exactly one of alpha_r and alpha_i is ±1 and the other is 0. When both are nonzero, the priority order above still applies (alpha_r wins).
- A requester must hold req_valid and its payload stable until it sees req_ready. The arbiter never drops a pending request. Starvation is bounded to one result per competing request.

## Timing
- Latency: a request accepted in cycle n appears with out_valid=1 in cycle n+1.
- Throughput: one result per cycle while out_ready=1. Back-to-back operation with both requesters valid alternates 0,1,0,1…
- out_ready=0 with out_valid=1: req_ready=00 and all outputs hold.
- Simultaneous drain and load: a new result replaces the consumed one in the same edge, and out_valid stays 1.
- Reset values: out_valid=0, out_amp_r=0, out_amp_i=0, out_id=0, out_tag=0, last_grant=1 (requester 0 wins the first tie), alpha_err=0.
- Reset mid-operation: a pending result is discarded. Requesters must re-present their requests after reset.

## Configuration
- ALPHA_ERR_EN defined:
  - Handshakes carrying an illegal alpha set alpha_err (sticky until rst). This covers both components 0, both components nonzero, or either component equal to −2.
  - The result is still produced per the product rules.
- ALPHA_ERR_EN undefined: the alpha_err port and its logic are absent. Illegal alpha behaves per the product rules only.

## Structure
- Shared package alpha_mult_pkg holds:
  - alpha encoding constants ALPHA_POS=2'sd1 and ALPHA_NEG=−2'sd1
  - a typedef for the complex amplitude struct {r, i} parameterised by COMPLEX_BIT
- Sub-module phase_mult: a combinational product per the rules above, instantiated once after the grant mux. The arbiter contains the mux, the round-robin pointer and the result register.

## Test plan
- Reset, then requester 0 only with alpha=(1,0), amp=(5,−3), tag=2 -> next cycle out_valid=1, out=(5,−3), out_id=0, out_tag=2.
- Both requesters valid for 4 cycles with out_ready=1 -> grants 0,1,0,1; out_id sequence 0,1,0,1 with no gaps.
- alpha=(0,1), amp=(7,2) -> out=(−2,7); alpha=(0,−1) -> out=(2,−7); alpha=(−1,0), amp=(−2^23,0) -> out=(−2^23,0) (wrap).
- out_ready=0 for 3 cycles while requester 1 is valid -> req_ready=00 and outputs stable; raise out_ready -> same-cycle handshake, new result next cycle.
- With ALPHA_ERR_EN, alpha=(0,0), amp=(9,9) -> out=(0,0) and alpha_err=1, and it stays 1 after later legal requests until rst.
- Assert rst while out_valid=1 -> out_valid=0 immediately (async) and the first tie after release is granted to requester 0.
